// File: rtl/bounded_repeat_vec_unit.sv
// Bounded-repetition unit for X{M,N}, X{1,N} and X{M,}. It keeps one bit per thread length,
// so overlapping start tokens are all tracked at the same time.
module bounded_repeat_vec_unit #(
  parameter int M_MIN = 12,
  parameter int N_MAX = 12,
  parameter int MODE  = 1,
  parameter int L     = (MODE == 2) ? M_MIN : N_MAX,
  parameter int CW    = $clog2(L + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in0,
  input  logic          char_match,
  output logic          out,
  output logic [CW-1:0] hi_count,
  output logic          drop
);

  localparam int M_EFF = (MODE == 0) ? 1 : M_MIN;

  if ((M_MIN < 1) || ((MODE != 2) && (N_MAX < M_MIN))) begin : g_param_check
    $error("bounded_repeat_vec_unit: illegal M_MIN/N_MAX/MODE combination");
  end

  logic [L:1] v_q, v_d;
  logic       drop_q, drop_d;
  logic [L:0] s;

  // Next-state computation: reset, hold, kill all threads, or advance them by one char
  always_comb begin
    s      = {v_q, in0};
    v_d    = v_q;
    drop_d = drop_q;
    if (rst) begin
      v_d    = '0;
      drop_d = 1'b0;
    end else if (!en) begin
      v_d    = v_q;
      drop_d = drop_q;
    end else if (!char_match) begin
      v_d    = '0;
      drop_d = 1'b0;
    end else begin
      v_d = s[L-1:0];
      if (MODE == 2) begin
        // Length M_MIN stands for ">= M_MIN", so it feeds back on itself
        v_d[L] = s[L-1] | v_q[L];
        drop_d = 1'b0;
      end else begin
        drop_d = v_q[L];
      end
    end
  end

  // Thread state updates on the falling edge to line up with the engine's char timing
  always_ff @(negedge clk) begin
    v_q    <= v_d;
    drop_q <= drop_d;
  end

  // Satisfied when any thread has reached the effective minimum length
  always_comb begin
    out = 1'b0;
    for (int k = 1; k <= L; k++) begin
      if (k >= M_EFF) begin
        out = out | v_q[k];
      end else begin
        out = out;
      end
    end
  end

  // Priority encode of the longest live thread
  always_comb begin
    hi_count = '0;
    for (int k = 1; k <= L; k++) begin
      if (v_q[k]) begin
        hi_count = CW'(k);
      end else begin
        hi_count = hi_count;
      end
    end
  end

  assign drop = (MODE == 2) ? 1'b0 : drop_q;

endmodule
